// File: rtl/pd_mem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, default base, FSM states
// and the lane helpers used for stores and loads.
package pd_mem_pkg;

  localparam logic [1:0]  SIZE_BYTE    = 2'd0;
  localparam logic [1:0]  SIZE_HALF    = 2'd1;
  localparam logic [1:0]  SIZE_WORD    = 2'd2;
  localparam logic [1:0]  SIZE_ILLEGAL = 2'd3;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h0100_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] mask;
    mask = '0;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << addr_lo;
      SIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: mask = 4'b1111;
      default:   mask = '0;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] data;
    case (size)
      SIZE_BYTE: data = {4{wdata[7:0]}};
      SIZE_HALF: data = {2{wdata[15:0]}};
      default:   data = wdata;
    endcase
    return data;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] addr_lo, input logic is_unsigned);
    logic [31:0] shifted;
    logic [31:0] result;
    result = word;
    case (size)
      SIZE_BYTE: begin
        shifted = word >> {addr_lo, 3'b000};
        result  = is_unsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        shifted = word >> {addr_lo[1], 4'b0000};
        result  = is_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised storage: one synchronous byte-masked write port, combinational read.
// Contents are never cleared; simulation preload is the only initialisation.
module dmem_bank #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [3:0]        wmask,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: fixed-latency request/response handshake,
// byte/half/word lanes with sign/zero extension, alignment and range fault detection.
module dmem_responder
  import pd_mem_pkg::*;
#(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned ADDR_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);
  localparam bit          DIRECT   = (LATENCY == 1);

  dmem_state_e state;
  logic [3:0]  cnt;

  logic [31:0] lat_addr;
  logic        lat_rw;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [31:0] lat_wdata;

  logic [31:0] acc_addr;
  logic        acc_rw;
  logic [1:0]  acc_size;
  logic        acc_unsigned;
  logic [31:0] acc_wdata;
  logic [31:0] acc_offset;
  logic        acc_err;
  logic        accept;
  logic        enter_resp;
  logic        bank_we;
  logic [31:0] bank_rdata;
  logic [31:0] load_data;
  logic [31:0] resp_data_next;

  assign accept = (state == IDLE) && req_valid;

  // With LATENCY=1 the access completes on the acceptance edge itself, before the
  // request fields are latched, so the live request drives the datapath while IDLE.
  always_comb begin
    acc_addr     = lat_addr;
    acc_rw       = lat_rw;
    acc_size     = lat_size;
    acc_unsigned = lat_unsigned;
    acc_wdata    = lat_wdata;
    if (state == IDLE) begin
      acc_addr     = req_addr;
      acc_rw       = req_rw;
      acc_size     = req_size;
      acc_unsigned = req_unsigned;
      acc_wdata    = req_wdata;
    end
  end

  // Unsigned offset compare also catches addresses below BASE_ADDR via wraparound.
  always_comb begin
    acc_offset = acc_addr - BASE_ADDR;
    acc_err    = 1'b0;
    if (acc_size == SIZE_ILLEGAL)                           acc_err = 1'b1;
    if ((acc_size == SIZE_HALF) && acc_addr[0])             acc_err = 1'b1;
    if ((acc_size == SIZE_WORD) && (acc_addr[1:0] != 2'b00)) acc_err = 1'b1;
    if (acc_offset >= SPAN)                                 acc_err = 1'b1;
  end

  always_comb begin
    enter_resp = 1'b0;
    if (accept && DIRECT)                      enter_resp = 1'b1;
    if ((state == BUSY) && (cnt == '0))        enter_resp = 1'b1;
  end

  assign bank_we        = enter_resp && acc_rw && !acc_err && !reset;
  assign load_data      = load_extend(bank_rdata, acc_size, acc_addr[1:0], acc_unsigned);
  assign resp_data_next = (acc_err || acc_rw) ? '0 : load_data;

  dmem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_bank (
    .clock (clock),
    .we    (bank_we),
    .wmask (lane_mask(acc_size, acc_addr[1:0])),
    .addr  (acc_offset[ADDR_W+1:2]),
    .wdata (store_lanes(acc_size, acc_wdata)),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      lat_addr     <= '0;
      lat_rw       <= 1'b0;
      lat_size     <= SIZE_BYTE;
      lat_unsigned <= 1'b0;
      lat_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_addr     <= req_addr;
            lat_rw       <= req_rw;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_wdata    <= req_wdata;
            req_ready    <= 1'b0;
            if (DIRECT) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= resp_data_next;
              resp_err   <= acc_err;
            end else begin
              state <= BUSY;
              cnt   <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= resp_data_next;
            resp_err   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with default parameters (LATENCY=2).
module tb_dmem_responder;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_rw;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(
    .LATENCY     (2),
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0100_0000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_rw       (req_rw),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Full transaction; lat counts edges from the acceptance edge (inclusive) to resp_valid.
  task automatic access(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clock); #1;
      guard++;
    end
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_word_rw;
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 32'h0100_0010, 2'd2, 1'b0, 32'hDEAD_BEEF, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_write_latency got=%0d exp=2", lat); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL word_write_resp got=%h/%b exp=0/0", rd, er); end
    access(1'b0, 32'h0100_0010, 2'd2, 1'b0, 32'h0, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_read_latency got=%0d exp=2", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin errors++; $display("FAIL word_read got=%h/%b exp=deadbeef/0", rd, er); end
  endtask

  task automatic test_subword_loads;
    logic [31:0] rd; logic er; int lat;
    access(1'b0, 32'h0100_0013, 2'd0, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF_FFDE || er !== 1'b0) begin errors++; $display("FAIL byte_signed got=%h/%b exp=ffffffde/0", rd, er); end
    access(1'b0, 32'h0100_0013, 2'd0, 1'b1, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_00DE) begin errors++; $display("FAIL byte_unsigned got=%h exp=000000de", rd); end
    access(1'b0, 32'h0100_0010, 2'd1, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF_BEEF || er !== 1'b0) begin errors++; $display("FAIL half_signed got=%h/%b exp=ffffbeef/0", rd, er); end
    access(1'b0, 32'h0100_0012, 2'd1, 1'b1, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_DEAD) begin errors++; $display("FAIL half_unsigned_hi got=%h exp=0000dead", rd); end
    access(1'b0, 32'h0100_0011, 2'd0, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF_FFBE) begin errors++; $display("FAIL byte_lane1 got=%h exp=ffffffbe", rd); end
  endtask

  task automatic test_byte_store;
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 32'h0100_0011, 2'd0, 1'b0, 32'hAAAA_AA55, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL byte_store_err got=%b exp=0", er); end
    access(1'b0, 32'h0100_0010, 2'd2, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD_55EF) begin errors++; $display("FAIL byte_store_merge got=%h exp=dead55ef", rd); end
    access(1'b1, 32'h0100_0012, 2'd1, 1'b0, 32'h1111_C0DE, rd, er, lat);
    access(1'b0, 32'h0100_0010, 2'd2, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hC0DE_55EF) begin errors++; $display("FAIL half_store_merge got=%h exp=c0de55ef", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 32'h0100_0000, 2'd2, 1'b0, 32'h1122_3344, rd, er, lat);
    access(1'b0, 32'h0100_0002, 2'd2, 1'b0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned_word got=%h/%b exp=0/1", rd, er); end
    access(1'b1, 32'h0100_0001, 2'd1, 1'b0, 32'h0000_AAAA, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned_half_write got=%h/%b exp=0/1", rd, er); end
    access(1'b0, 32'h00FF_FFFC, 2'd2, 1'b0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL below_base got=%h/%b exp=0/1", rd, er); end
    access(1'b0, 32'h0100_1000, 2'd2, 1'b0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL past_end got=%b exp=1", er); end
    access(1'b1, 32'h0100_0000, 2'd3, 1'b0, 32'hFFFF_FFFF, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL illegal_size got=%b exp=1", er); end
    access(1'b1, 32'h0100_0FFC, 2'd2, 1'b0, 32'hA5A5_5A5A, rd, er, lat);
    access(1'b0, 32'h0100_0FFC, 2'd2, 1'b0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'hA5A5_5A5A) begin errors++; $display("FAIL last_word got=%h/%b exp=a5a55a5a/0", rd, er); end
    access(1'b0, 32'h0100_0000, 2'd2, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h1122_3344 || er !== 1'b0) begin errors++; $display("FAIL storage_unchanged got=%h/%b exp=11223344/0", rd, er); end
  endtask

  task automatic test_resp_stall;
    logic [31:0] rd0; logic er0; int lat;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h0100_0010; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = '0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_after_accept got=%b exp=0", req_ready); end
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clock); #1; lat++; end
    checks++; if (lat !== 2) begin errors++; $display("FAIL stall_latency got=%0d exp=2", lat); end
    rd0 = resp_rdata; er0 = resp_err;
    checks++; if (rd0 !== 32'hC0DE_55EF || er0 !== 1'b0) begin errors++; $display("FAIL stall_data got=%h/%b exp=c0de55ef/0", rd0, er0); end
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== 32'hC0DE_55EF || resp_err !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got v=%b rdy=%b d=%h e=%b exp v=1 rdy=0 d=c0de55ef e=0",
                 i, resp_valid, req_ready, resp_rdata, resp_err);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL stall_release got rdy=%b v=%b exp rdy=1 v=0", req_ready, resp_valid); end
  endtask

  task automatic test_reset_in_busy;
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 32'h0100_0020, 2'd2, 1'b0, 32'hCAFE_F00D, rd, er, lat);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h0100_0020; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'h1234_5678;
    @(posedge clock); #1;
    req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL busy_before_reset got v=%b rdy=%b exp v=0 rdy=0", resp_valid, req_ready); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL reset_in_busy got v=%b rdy=%b exp v=0 rdy=1", resp_valid, req_ready); end
    @(posedge clock); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL no_resp_after_abort got=%b exp=0", resp_valid); end
    access(1'b0, 32'h0100_0020, 2'd2, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin errors++; $display("FAIL aborted_write_discarded got=%h/%b exp=cafef00d/0", rd, er); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_rw = 1'b0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b0;
    test_reset();
    test_word_rw();
    test_subword_loads();
    test_byte_store();
    test_errors();
    test_resp_stall();
    test_reset_in_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2; cycles from request acceptance to resp_valid, legal range 1..15.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024; number of 32-bit storage words.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h01000000; byte address of word 0.
REQ-004 SHALL have port clock  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  responder can accept a request.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_rw  in  1  0=read, 1=write.
REQ-010 SHALL have port req_size  in  2  access size: 0=byte, 1=half, 2=word, 3=illegal.
REQ-011 SHALL have port req_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
REQ-012 SHALL have port req_wdata  in  32  store data, LSB-aligned.
REQ-013 SHALL have port resp_valid  out  1  response present.
REQ-014 SHALL have port resp_ready  in  1  initiator accepts response.
REQ-015 SHALL have port resp_rdata  out  32  load result, extended to 32 bits; 0 for writes and errors.
REQ-016 SHALL have port resp_err  out  1  access faulted.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY and RESP; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-018 SHALL accept a request on the edge where state=IDLE and req_valid=1, and latch addr, rw, size, unsigned and wdata.
REQ-019 SHALL go IDLE->RESP on acceptance when LATENCY=1; otherwise IDLE->BUSY with a 4-bit counter loaded with LATENCY-2.
REQ-020 SHALL decrement the counter in BUSY and go BUSY->RESP on the edge where the counter is 0; resp_valid therefore asserts exactly LATENCY cycles after the acceptance edge.
REQ-021 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1, then return to IDLE on that edge.
REQ-022 SHALL not accept a new request on the RESP->IDLE edge; the earliest next acceptance is one cycle later. Only one access is outstanding.
REQ-023 SHALL flag an error when size=3, when a half access has addr[0]=1, when a word access has addr[1:0]!=0, or when addr-BASE_ADDR falls outside 0..4*DEPTH_WORDS-1 (unsigned compare, so addresses below BASE wrap and are caught).
REQ-024 SHALL index storage by word (addr-BASE_ADDR)>>2 and select byte lane addr[1:0], or half lane addr[1].
REQ-025 SHALL commit a write on the edge entering RESP, updating only the addressed lanes with the low byte, low half or full req_wdata; an error SHALL suppress the write.
REQ-026 SHALL sample read data on the edge entering RESP, right-shift the selected lane to bit 0, and extend it per req_unsigned; word loads ignore req_unsigned.
REQ-027 SHALL present resp_rdata=0 for writes and for any error.

Reset
REQ-028 SHALL, on reset, force state=IDLE, counter=0, req_ready=1 after the reset edge, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-029 SHALL, on reset in BUSY or RESP, abort the access and discard any uncommitted write.
REQ-030 SHALL not clear storage on reset; contents are initialised only by simulation preload.

Structure
REQ-031 SHALL take the access-size encodings, default BASE_ADDR and the FSM state enum from shared package pd_mem_pkg.
REQ-032 SHALL place storage in sub-module dmem_bank: one synchronous write port with a 4-bit byte mask and a combinational read; the FSM and lane logic stay in dmem_responder.

Verification
REQ-033 SHALL cover: word write 0xDEADBEEF @0x01000010, then word read @0x01000010 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid exactly 2 cycles after each acceptance.
REQ-034 SHALL cover: after REQ-033 data, byte read @0x01000013 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; half read @0x01000010 signed -> 0xFFFFBEEF.
REQ-035 SHALL cover: byte write 0x55 @0x01000011, then word read @0x01000010 -> 0xDEAD55EF.
REQ-036 SHALL cover: word read @0x01000002, half write @0x01000001, and read @0x00FFFFFC -> each resp_err=1, resp_rdata=0, storage unchanged.
REQ-037 SHALL cover: resp_ready held 0 for 5 cycles in RESP -> outputs stable and req_ready=0 throughout; req_ready=1 one cycle after the resp handshake.
REQ-038 SHALL cover: reset asserted in BUSY during a word write 0x12345678 @0x01000020 -> resp_valid=0 and state IDLE after the reset edge, and a subsequent read of that address returns the prior contents.
